// File: rtl/scv_rominit_loader.sv
// scv_rominit_loader: splits the HPS ioctl download stream into the per-ROM
// ROMINIT byte-write bus, tracks load completeness and gates the core reset.
module scv_rominit_loader #(
  parameter int unsigned BOOT_LEN = 4096,
  parameter int unsigned CHR_LEN  = 1024,
  parameter int unsigned APU_LEN  = 2048,
  parameter int unsigned CART_MAX = 131072,
  parameter int unsigned IDX_BIOS = 0,
  parameter int unsigned IDX_CART = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        IOCTL_DOWNLOAD,
  input  logic [7:0]  IOCTL_INDEX,
  input  logic [24:0] IOCTL_ADDR,
  input  logic [7:0]  IOCTL_DATA,
  input  logic        IOCTL_WR,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic        ROMINIT_SEL_APU,
  output logic        ROMINIT_SEL_CART,
  output logic [24:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic [24:0] CART_BYTES,
  output logic        BIOS_OK,
  output logic        CART_OK,
  output logic        ERR,
  output logic        CORE_HOLD
);

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;

  localparam logic [AW-1:0] L_BOOT_END = AW'(BOOT_LEN);
  localparam logic [AW-1:0] L_CHR_END  = AW'(BOOT_LEN + CHR_LEN);
  localparam logic [AW-1:0] L_TOTAL    = AW'(BOOT_LEN + CHR_LEN + APU_LEN);
  localparam logic [AW-1:0] L_CART_MAX = AW'(CART_MAX);

  // Select bit positions: [0] boot, [1] chr, [2] apu, [3] cart
  localparam logic [SW-1:0] SEL_BOOT = 4'b0001;
  localparam logic [SW-1:0] SEL_CHR  = 4'b0010;
  localparam logic [SW-1:0] SEL_APU  = 4'b0100;
  localparam logic [SW-1:0] SEL_CART = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_BIOS,
    ST_LOAD_CART,
    ST_LOAD_SKIP
  } state_t;

  state_t          r_state, w_state;
  logic            r_armed, r_dl_prev;
  logic [AW-1:0]   r_cnt, w_cnt;
  logic            r_err, w_err;
  logic            r_bios_ok, w_bios_ok;
  logic            r_cart_ok, w_cart_ok;
  logic [AW-1:0]   r_cart_bytes, w_cart_bytes;
  logic [SW-1:0]   r_sel, w_sel;
  logic            r_valid, w_valid;
  logic [AW-1:0]   r_addr, w_addr;
  logic [DW-1:0]   r_data, w_data;
  logic            r_hold;
  logic [SW-1:0]   w_fwd_sel;
  logic [AW-1:0]   w_fwd_addr;
  logic            w_start;

  // A session only opens on a fresh rising edge of DOWNLOAD after it was seen low
  assign w_start = IOCTL_DOWNLOAD & ~r_dl_prev & r_armed;

  // Next-state, region decode and status update
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_err        = r_err;
    w_bios_ok    = r_bios_ok;
    w_cart_ok    = r_cart_ok;
    w_cart_bytes = r_cart_bytes;
    w_sel        = r_sel;
    w_valid      = 1'b0;
    w_addr       = r_addr;
    w_data       = r_data;
    w_fwd_sel    = '0;
    w_fwd_addr   = IOCTL_ADDR;
    unique case (r_state)
      ST_IDLE: begin
        w_sel = '0;
        if (w_start) begin
          w_cnt = '0;
          w_err = 1'b0;
          if (IOCTL_INDEX == 8'(IDX_BIOS)) begin
            w_state   = ST_LOAD_BIOS;
            w_bios_ok = 1'b0;
          end else if (IOCTL_INDEX == 8'(IDX_CART)) begin
            w_state   = ST_LOAD_CART;
            w_cart_ok = 1'b0;
          end else begin
            w_state = ST_LOAD_SKIP;
          end
        end
      end
      default: begin
        if (!IOCTL_DOWNLOAD) begin
          w_state = ST_IDLE;
          w_sel   = '0;
          if (r_state == ST_LOAD_BIOS) begin
            w_bios_ok = (r_cnt == L_TOTAL) && !r_err;
          end
          if (r_state == ST_LOAD_CART) begin
            w_cart_bytes = r_cnt;
            w_cart_ok    = (r_cnt != '0) && (r_cnt <= L_CART_MAX) && !r_err;
          end
        end else if (IOCTL_WR) begin
          w_cnt = (r_cnt == '1) ? r_cnt : r_cnt + AW'(1);
          if (IOCTL_ADDR != r_cnt) w_err = 1'b1;
          if (r_state == ST_LOAD_BIOS) begin
            if (IOCTL_ADDR < L_BOOT_END) begin
              w_fwd_sel = SEL_BOOT;
            end else if (IOCTL_ADDR < L_CHR_END) begin
              w_fwd_sel  = SEL_CHR;
              w_fwd_addr = IOCTL_ADDR - L_BOOT_END;
            end else if (IOCTL_ADDR < L_TOTAL) begin
              w_fwd_sel  = SEL_APU;
              w_fwd_addr = IOCTL_ADDR - L_CHR_END;
            end else begin
              w_err = 1'b1;
            end
          end else if (r_state == ST_LOAD_CART) begin
            if (IOCTL_ADDR < L_CART_MAX) w_fwd_sel = SEL_CART;
            else                         w_err     = 1'b1;
          end
          if (w_fwd_sel != '0) begin
            w_valid = 1'b1;
            w_sel   = w_fwd_sel;
            w_addr  = w_fwd_addr;
            w_data  = IOCTL_DATA;
          end
        end
      end
    endcase
  end

  // State, datapath and status registers; core hold lags the status by one cycle
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state      <= ST_IDLE;
      r_armed      <= 1'b0;
      r_dl_prev    <= 1'b0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_bios_ok    <= 1'b0;
      r_cart_ok    <= 1'b0;
      r_cart_bytes <= '0;
      r_sel        <= '0;
      r_valid      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_hold       <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_armed      <= r_armed | ~IOCTL_DOWNLOAD;
      r_dl_prev    <= IOCTL_DOWNLOAD;
      r_cnt        <= w_cnt;
      r_err        <= w_err;
      r_bios_ok    <= w_bios_ok;
      r_cart_ok    <= w_cart_ok;
      r_cart_bytes <= w_cart_bytes;
      r_sel        <= w_sel;
      r_valid      <= w_valid;
      r_addr       <= w_addr;
      r_data       <= w_data;
      r_hold       <= (r_state != ST_IDLE) | ~r_bios_ok | ~r_cart_ok;
    end
  end

  assign ROMINIT_SEL_BOOT = r_sel[0];
  assign ROMINIT_SEL_CHR  = r_sel[1];
  assign ROMINIT_SEL_APU  = r_sel[2];
  assign ROMINIT_SEL_CART = r_sel[3];
  assign ROMINIT_ADDR     = r_addr;
  assign ROMINIT_DATA     = r_data;
  assign ROMINIT_VALID    = r_valid;
  assign CART_BYTES       = r_cart_bytes;
  assign BIOS_OK          = r_bios_ok;
  assign CART_OK          = r_cart_ok;
  assign ERR              = r_err;
  assign CORE_HOLD        = r_hold;

endmodule

// File: tb/tb_scv_rominit_loader.sv
// Scoreboard bench for scv_rominit_loader: random data streams, reference
// region map and session model, monitor popping expected writes.
module tb_scv_rominit_loader;

  localparam int unsigned BOOT_LEN = 4096;
  localparam int unsigned CHR_LEN  = 1024;
  localparam int unsigned APU_LEN  = 2048;
  localparam int unsigned CART_MAX = 8192;
  localparam int unsigned TOTAL    = BOOT_LEN + CHR_LEN + APU_LEN;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        IOCTL_DOWNLOAD = 1'b0;
  logic [7:0]  IOCTL_INDEX = '0;
  logic [24:0] IOCTL_ADDR = '0;
  logic [7:0]  IOCTL_DATA = '0;
  logic        IOCTL_WR = 1'b0;
  logic        ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic [24:0] CART_BYTES;
  logic        BIOS_OK, CART_OK, ERR, CORE_HOLD;

  typedef struct packed {
    logic [3:0]  sel;
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference status of the loader as seen from outside
  bit   m_bios_ok = 0;
  bit   m_cart_ok = 0;
  bit   m_err     = 0;
  int   m_cart_bytes = 0;

  // Bundle layout as (base, length) per region, sel bit = region number
  int unsigned reg_base [3] = '{0, BOOT_LEN, BOOT_LEN + CHR_LEN};
  int unsigned reg_len  [3] = '{BOOT_LEN, CHR_LEN, APU_LEN};

  always #5 CLK = ~CLK;

  scv_rominit_loader #(
    .BOOT_LEN(BOOT_LEN), .CHR_LEN(CHR_LEN), .APU_LEN(APU_LEN),
    .CART_MAX(CART_MAX), .IDX_BIOS(0), .IDX_CART(1)
  ) dut (
    .CLK(CLK), .RES(RES),
    .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
    .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DATA(IOCTL_DATA), .IOCTL_WR(IOCTL_WR),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_SEL_APU(ROMINIT_SEL_APU), .ROMINIT_SEL_CART(ROMINIT_SEL_CART),
    .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA),
    .ROMINIT_VALID(ROMINIT_VALID), .CART_BYTES(CART_BYTES),
    .BIOS_OK(BIOS_OK), .CART_OK(CART_OK), .ERR(ERR), .CORE_HOLD(CORE_HOLD)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] sel_bus();
    return {ROMINIT_SEL_CART, ROMINIT_SEL_APU, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},  64'(ROMINIT_VALID), 64'(0));
    chk({tag, "_sel"},    64'(sel_bus()), 64'(0));
    chk({tag, "_addr"},   64'(ROMINIT_ADDR), 64'(0));
    chk({tag, "_data"},   64'(ROMINIT_DATA), 64'(0));
    chk({tag, "_bytes"},  64'(CART_BYTES), 64'(0));
    chk({tag, "_bios"},   64'(BIOS_OK), 64'(0));
    chk({tag, "_cart"},   64'(CART_OK), 64'(0));
    chk({tag, "_err"},    64'(ERR), 64'(0));
    chk({tag, "_hold"},   64'(CORE_HOLD), 64'(1));
  endtask

  // Monitor: every VALID must match the oldest expected write
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (ROMINIT_VALID === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("rominit_write", 64'({sel_bus(), ROMINIT_ADDR, ROMINIT_DATA}), 64'(e));
        end
      end
    end
  end

  // One download session: n bytes, gap idle cycles between writes (<0 random),
  // address skip of 16 from byte jump_at, reset pulse at byte res_at
  task automatic run_session(input int idx, input int n, input int gap,
                             input int jump_at, input int res_at, input string tag);
    int          cnt = 0;
    bit          active = 1;
    bit          err = 0;
    int          g;
    logic [24:0] a;
    logic [7:0]  d;
    exp_t        e;
    @(posedge CLK); #1 IOCTL_DOWNLOAD = 1'b0; IOCTL_WR = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    // Start cycle carries a stray write that must be ignored
    IOCTL_DOWNLOAD = 1'b1; IOCTL_INDEX = 8'(idx);
    IOCTL_WR = 1'b1; IOCTL_ADDR = '0; IOCTL_DATA = 8'($urandom);
    if (idx == 0) m_bios_ok = 0;
    if (idx == 1) m_cart_ok = 0;
    for (int k = 0; k < n; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin @(posedge CLK); #1 IOCTL_WR = 1'b0; end
      @(posedge CLK); #1;
      a = 25'(k) + ((jump_at >= 0 && k >= jump_at) ? 25'd16 : 25'd0);
      d = 8'($urandom);
      IOCTL_WR = 1'b1; IOCTL_ADDR = a; IOCTL_DATA = d;
      if (k == res_at) begin
        RES = 1'b1;
        active = 0; err = 0;
        m_bios_ok = 0; m_cart_ok = 0; m_err = 0; m_cart_bytes = 0;
        @(posedge CLK); #1 RES = 1'b0;
        @(negedge CLK);
        chk_reset_vals({tag, "_midres"});
      end else if (active) begin
        cnt++;
        if (int'(a) != cnt - 1) err = 1;
        if (idx == 0) begin
          bit hit = 0;
          for (int r = 0; r < 3; r++) begin
            if (int'(a) >= int'(reg_base[r]) && int'(a) < int'(reg_base[r] + reg_len[r])) begin
              e.sel = 4'(1 << r); e.addr = 25'(int'(a) - int'(reg_base[r])); e.data = d;
              q.push_back(e);
              hit = 1;
            end
          end
          if (!hit) err = 1;
        end else if (idx == 1) begin
          if (int'(a) < int'(CART_MAX)) begin
            e.sel = 4'b1000; e.addr = a; e.data = d;
            q.push_back(e);
          end else begin
            err = 1;
          end
        end
      end
    end
    // Download falls with a write on the same cycle, which must be dropped
    @(posedge CLK); #1 IOCTL_DOWNLOAD = 1'b0;
    IOCTL_WR = 1'b1; IOCTL_ADDR = 25'(n); IOCTL_DATA = 8'($urandom);
    @(posedge CLK); #1 IOCTL_WR = 1'b0;
    if (active) begin
      m_err = err;
      if (idx == 0) m_bios_ok = (cnt == int'(TOTAL)) && !err;
      if (idx == 1) begin
        m_cart_bytes = cnt;
        m_cart_ok = (cnt != 0) && (cnt <= int'(CART_MAX)) && !err;
      end
    end
    @(negedge CLK);
    chk({tag, "_bios_ok"},    64'(BIOS_OK), 64'(m_bios_ok));
    chk({tag, "_cart_ok"},    64'(CART_OK), 64'(m_cart_ok));
    chk({tag, "_err"},        64'(ERR), 64'(m_err));
    chk({tag, "_cart_bytes"}, 64'(CART_BYTES), 64'(m_cart_bytes));
    chk({tag, "_sel_idle"},   64'(sel_bus()), 64'(0));
    chk({tag, "_hold_end1"},  64'(CORE_HOLD), 64'(1));
    chk({tag, "_drained"},    64'(q.size()), 64'(0));
    @(negedge CLK);
    chk({tag, "_hold_end2"},  64'(CORE_HOLD), 64'(!(m_bios_ok && m_cart_ok)));
  endtask

  // Watchdog bound on total run length
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("por");
    @(posedge CLK); #1 RES = 1'b0;

    run_session(0, int'(TOTAL),     0, -1, -1, "bundle_good");
    run_session(0, int'(TOTAL) + 1, 0, -1, -1, "bundle_long");
    run_session(0, int'(TOTAL),     0, -1, -1, "bundle_reload");
    run_session(1, int'(CART_MAX),  3, -1, -1, "cart_max_4th");
    run_session(1, 64,              0, 16, -1, "cart_jump");
    run_session(5, 50,             -1, -1, -1, "skip_idx5");
    run_session(1, 300,             0, -1, 100, "cart_reset");
    run_session(1, 300,            -1, -1, -1, "cart_after_res");
    run_session(0, int'(TOTAL),    -1, -1, -1, "bundle_rand");
    run_session(1, int'(CART_MAX) + 1, 0, -1, -1, "cart_over");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
